// File: rtl/vga_text_term.sv
// Text-mode terminal: keeps a COLS x ROWS character buffer fed by an ASCII stream
// and renders it as 24-bit pixels through an external font ROM, with a blinking underline cursor.
module vga_text_term #(
    parameter int          COLS         = 70,
    parameter int          ROWS         = 30,
    parameter int          CHAR_W       = 9,
    parameter int          CHAR_H       = 16,
    parameter logic [23:0] FG           = 24'hFFFFFF,
    parameter logic [23:0] BG           = 24'h000000,
    parameter int          BLINK_CYCLES = 12_500_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     asc_valid,
    input  logic [7:0]               asc,
    output logic                     asc_ready,
    input  logic [9:0]               h_addr,
    input  logic [9:0]               v_addr,
    output logic [11:0]              font_addr,
    input  logic [CHAR_W-1:0]        font_row,
    output logic [23:0]              vga_data,
    output logic [$clog2(COLS)-1:0]  cur_col,
    output logic [$clog2(ROWS)-1:0]  cur_row,
    output logic                     busy
);
    localparam int N   = ROWS * COLS;
    localparam int AW  = $clog2(N);
    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int PXW = $clog2(CHAR_W);
    localparam int PYW = $clog2(CHAR_H);
    localparam int BW  = $clog2(BLINK_CYCLES + 1);

    typedef enum logic [1:0] {INIT_CLR, IDLE, WRITE, LINE_CLR} state_t;

    state_t         state_reg, state_next;
    logic [AW-1:0]  clr_idx_reg, clr_idx_next;
    logic [CW-1:0]  cur_col_reg, cur_col_next;
    logic [RW-1:0]  cur_row_reg, cur_row_next;
    logic [RW-1:0]  top_reg, top_next;
    logic [BW-1:0]  blink_cnt_reg;
    logic           blink_reg;

    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [7:0]     wr_data;
    logic [7:0]     buf_mem [N];

    // The screen is a ring of rows; top_reg is the physical row shown as logical row 0.
    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] r, input logic [RW-1:0] t);
        logic [RW:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= (RW+1)'(ROWS))
            s = s - (RW+1)'(ROWS);
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] pr, input logic [CW-1:0] c);
        return AW'(pr) * AW'(COLS) + AW'(c);
    endfunction

    logic          accept, is_print, is_nl, is_bs, line_adv, scroll, bs_move;
    logic [CW-1:0] bs_col;
    logic [RW-1:0] bs_row;

    assign accept   = asc_valid && (state_reg == IDLE);
    assign is_print = (asc >= 8'h20) && (asc <= 8'h7E);
    assign is_nl    = (asc == 8'h0D) || (asc == 8'h0A);
    assign is_bs    = (asc == 8'h08);
    assign line_adv = accept && (is_nl || (is_print && (cur_col_reg == CW'(COLS-1))));
    assign scroll   = line_adv && (cur_row_reg == RW'(ROWS-1));
    assign bs_move  = accept && is_bs && ((cur_col_reg != '0) || (cur_row_reg != '0));
    assign bs_col   = (cur_col_reg != '0) ? cur_col_reg - 1'b1 : CW'(COLS-1);
    assign bs_row   = (cur_col_reg != '0) ? cur_row_reg : cur_row_reg - 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= INIT_CLR;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT_CLR: if (clr_idx_reg == AW'(N-1))    state_next = IDLE;
            IDLE:     if (accept)                     state_next = scroll ? LINE_CLR : WRITE;
            WRITE:                                    state_next = IDLE;
            LINE_CLR: if (clr_idx_reg == AW'(COLS-1)) state_next = IDLE;
            default:                                  state_next = INIT_CLR;
        endcase
    end

    always_comb begin
        asc_ready = 1'b0;
        busy      = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = 8'h20;
        case (state_reg)
            INIT_CLR: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = clr_idx_reg;
            end
            IDLE: begin
                asc_ready = 1'b1;
                if (accept && is_print) begin
                    wr_en   = 1'b1;
                    wr_addr = cell_addr(phys_row(cur_row_reg, top_reg), cur_col_reg);
                    wr_data = asc;
                end else if (bs_move) begin
                    wr_en   = 1'b1;
                    wr_addr = cell_addr(phys_row(bs_row, top_reg), bs_col);
                end
            end
            LINE_CLR: begin
                // top_reg has already advanced, so logical row ROWS-1 is the freshly exposed row.
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = cell_addr(phys_row(RW'(ROWS-1), top_reg), CW'(clr_idx_reg));
            end
            default: ;
        endcase
    end

    always_comb begin
        cur_col_next = cur_col_reg;
        cur_row_next = cur_row_reg;
        top_next     = top_reg;
        clr_idx_next = '0;
        if ((state_reg == INIT_CLR || state_reg == LINE_CLR) && state_next == state_reg)
            clr_idx_next = clr_idx_reg + 1'b1;
        if (line_adv) begin
            cur_col_next = '0;
            if (scroll)
                top_next = (top_reg == RW'(ROWS-1)) ? '0 : top_reg + 1'b1;
            else
                cur_row_next = cur_row_reg + 1'b1;
        end else if (accept && is_print) begin
            cur_col_next = cur_col_reg + 1'b1;
        end else if (bs_move) begin
            cur_col_next = bs_col;
            cur_row_next = bs_row;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_idx_reg   <= '0;
            cur_col_reg   <= '0;
            cur_row_reg   <= '0;
            top_reg       <= '0;
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
        end else begin
            clr_idx_reg <= clr_idx_next;
            cur_col_reg <= cur_col_next;
            cur_row_reg <= cur_row_next;
            top_reg     <= top_next;
            if (blink_cnt_reg == BW'(BLINK_CYCLES-1)) begin
                blink_cnt_reg <= '0;
                blink_reg     <= ~blink_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    assign cur_col = cur_col_reg;
    assign cur_row = cur_row_reg;

    // Render stage 0: split the pixel position into cell and in-cell offsets.
    logic [9:0]     h_col, v_row;
    logic [PXW-1:0] px0;
    logic [PYW-1:0] py0;
    logic           in0, hit0;
    logic [AW-1:0]  rd_addr;

    always_comb begin
        h_col   = h_addr / 10'(CHAR_W);
        v_row   = v_addr / 10'(CHAR_H);
        px0     = PXW'(h_addr % 10'(CHAR_W));
        py0     = PYW'(v_addr % 10'(CHAR_H));
        in0     = (int'(h_addr) < COLS * CHAR_W) && (int'(v_addr) < ROWS * CHAR_H);
        rd_addr = in0 ? cell_addr(phys_row(RW'(v_row), top_reg), CW'(h_col)) : '0;
        hit0    = in0 && blink_reg && (h_col == 10'(cur_col_reg)) &&
                  (v_row == 10'(cur_row_reg)) && (py0 >= PYW'(CHAR_H-2));
    end

    logic [7:0] rd_char_reg;

    always_ff @(posedge clk) begin
        if (wr_en)
            buf_mem[wr_addr] <= wr_data;
        rd_char_reg <= buf_mem[rd_addr];
    end

    logic [PXW-1:0] px1_reg, px2_reg;
    logic [PYW-1:0] py1_reg;
    logic           in1_reg, in2_reg, hit1_reg, hit2_reg, rd_vld_reg;
    logic [23:0]    vga_data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px1_reg      <= '0;
            py1_reg      <= '0;
            in1_reg      <= 1'b0;
            hit1_reg     <= 1'b0;
            rd_vld_reg   <= 1'b0;
            px2_reg      <= '0;
            in2_reg      <= 1'b0;
            hit2_reg     <= 1'b0;
            vga_data_reg <= BG;
        end else begin
            px1_reg      <= px0;
            py1_reg      <= py0;
            in1_reg      <= in0;
            hit1_reg     <= hit0;
            rd_vld_reg   <= 1'b1;
            px2_reg      <= px1_reg;
            in2_reg      <= in1_reg;
            hit2_reg     <= hit1_reg;
            vga_data_reg <= (in2_reg && (font_row[px2_reg] || hit2_reg)) ? FG : BG;
        end
    end

    assign font_addr = {rd_vld_reg ? rd_char_reg : 8'h00, 4'(py1_reg)};
    assign vga_data  = vga_data_reg;

endmodule
